accel_spi_reader: RTL and testbench
===================================

Name: accel_spi_reader

Overview:
- SPI master that polls a 3-axis accelerometer and presents signed 8-bit X/Y acceleration samples.
- Its outputs drive the accel_x/accel_y inputs of the ball positioner.
- After reset it issues one configuration write. It then periodically reads the X and Y high-byte data registers and updates both outputs atomically.
- SPI mode 3 (CPOL=1, CPHA=1), MSB first, 16-bit transactions.

Parameters:
- CLK_DIV, 25: SCK half-period in clk cycles (50 MHz clk -> 1 MHz SCK); must be >= 1.
- POLL_PERIOD, 500000: clk cycles between poll starts; must be >= 80*CLK_DIV.
- INIT_ADDR, 8'h2D: register address of the post-reset configuration write.
- INIT_DATA, 8'h08: data byte of the configuration write (measure mode).
- X_ADDR, 8'h33: register address of the X data high byte.
- Y_ADDR, 8'h35: register address of the Y data high byte.

Ports:
- clk  input  1  system clock; the block uses this single clock.
- arst_n  input  1  asynchronous active-low reset.
- o_accel_x  output  8  latest X sample, two's complement.
- o_accel_y  output  8  latest Y sample, two's complement.
- o_valid  output  1  one-cycle pulse when o_accel_x/o_accel_y update.
- o_spi_sck  output  1  SPI clock, idles high.
- o_spi_cs_n  output  1  chip select, active low.
- o_spi_mosi  output  1  master out.
- i_spi_miso  input  1  master in; used directly, no synchronizer (SCK is far slower than clk).

Behaviour:
- Reset (async, immediate, including mid-transaction): o_accel_x=0, o_accel_y=0, o_valid=0, o_spi_sck=1, o_spi_cs_n=1, o_spi_mosi=0, poll timer=0, FSM=S_INIT. All SPI outputs are registered.
- Command word is 16 bits, MSB first:
  - bit15 = R/nW (1 = read).
  - bit14 = 0 (single byte).
  - bits13:8 = address[5:0].
  - bits7:0 = write data, or 0 for a read.
  - Init word = {2'b00, INIT_ADDR[5:0], INIT_DATA}; X read = {2'b10, X_ADDR[5:0], 8'h00}; Y read likewise with Y_ADDR.
- Transaction timing, with D = CLK_DIV and cycle 0 = cycle in which cs_n goes low:
  - For bit k = 0..15: at cycle (2k+1)*D, sck goes 0 and mosi takes word bit (15-k). At cycle (2k+2)*D, sck goes 1 and i_spi_miso is sampled into the receive shift register.
  - Cycle 33*D: cs_n goes 1. mosi goes 0 and holds 0 while cs_n = 1.
  - Cycle 34*D: earliest cs_n fall of the next transaction. One transaction slot = 34*D cycles.
  - Received byte = the last 8 samples, MSB first. The first 8 samples are discarded.
- FSM states:
  - S_INIT: perform the init write. -> S_IDLE.
  - S_IDLE: wait for a poll tick. -> S_RD_X.
  - S_RD_X: read X, hold the byte internally. -> S_RD_Y (directly after the X slot, including its gap).
  - S_RD_Y: read Y. -> S_IDLE.
- Output update: at the cycle the S_RD_Y slot ends (34*D after its cs_n fall), load both o_accel_x (held X byte) and o_accel_y in the same cycle, and pulse o_valid for exactly 1 cycle. Outputs hold their values otherwise.
- Poll timer:
  - Counts 0..POLL_PERIOD-1 and wraps; the tick is the cycle the count equals POLL_PERIOD-1. The timer starts counting in S_INIT.
  - A tick seen while the FSM is not in S_IDLE is dropped, not queued. The first poll is therefore the first tick after init completes.
  - Timer width is $clog2(POLL_PERIOD).
- There is no error detection. MISO all-ones reads 0xFF (-1) and MISO all-zeros reads 0x00; both are passed through unchanged.

Test Plan:
- Reset, sim params CLK_DIV=2, POLL_PERIOD=200 -> during and after reset: sck=1, cs_n=1, mosi=0, o_accel_x=o_accel_y=0, o_valid=0.
- Reset release -> first CS window shifts MOSI 0x2D08 (bits 0x2D then 0x08, bit15=0), 16 sck rising edges, cs_n high at cycle 66 of the window; no o_valid pulse.
- Slave model drives X byte 0x12 and Y byte 0xF0 on the second byte of each read -> MOSI command bytes 0xB3 then 0xB5. After the Y slot: o_accel_x=0x12, o_accel_y=0xF0 (-16), updated in the same cycle, o_valid high for exactly 1 cycle.
- Timing check, CLK_DIV=2 -> cs_n fall to first sck fall = 2 cycles; sck period 4 cycles; last rising edge to cs_n rise = 2 cycles; cs_n high >= 2 cycles between X and Y.
- Slave changes to X=0x80, Y=0x7F -> values stay 0x12/0xF0 until the next poll completes, then become 0x80/0x7F with one o_valid pulse; consecutive o_valid pulses are 200 cycles apart.
- arst_n asserted mid S_RD_X -> cs_n=1 and sck=1 asynchronously, outputs 0. After release, the init write 0x2D08 repeats before any read.

Source files
------------

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI mode-3 master that configures an accelerometer and polls X/Y high bytes
module accel_spi_reader #(
    parameter int          CLK_DIV     = 25,
    parameter int          POLL_PERIOD = 500000,
    parameter logic [7:0]  INIT_ADDR   = 8'h2D,
    parameter logic [7:0]  INIT_DATA   = 8'h08,
    parameter logic [7:0]  X_ADDR      = 8'h33,
    parameter logic [7:0]  Y_ADDR      = 8'h35
) (
    input  logic       clk,
    input  logic       arst_n,
    output logic [7:0] o_accel_x,
    output logic [7:0] o_accel_y,
    output logic       o_valid,
    output logic       o_spi_sck,
    output logic       o_spi_cs_n,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);
    localparam int TW = $clog2(POLL_PERIOD);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD_X, S_RD_Y} state_t;
    state_t          r_state, w_state_next;
    logic            r_active;
    logic [DW-1:0]   r_div;
    logic [5:0]      r_half;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_rx, r_x_hold;
    logic            w_step, w_end, w_tick, w_start, w_bit;
    logic [15:0]     w_word;
    assign w_step = r_active && (r_div == DW'(CLK_DIV - 1));
    assign w_end  = w_step && (r_half == 6'd33);
    assign w_tick = (r_timer == TW'(POLL_PERIOD - 1));
    assign w_word = (r_state == S_INIT) ? {2'b00, INIT_ADDR[5:0], INIT_DATA}
                  : {2'b10, (r_state == S_RD_X) ? X_ADDR[5:0] : Y_ADDR[5:0], 8'h00};
    assign w_bit  = w_word[4'd15 - r_half[4:1]];
    // state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= S_INIT;
        else         r_state <= w_state_next;
    end
    // next state and slot start; the Y read starts in the same cycle the X slot ends
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_INIT: begin
                w_start = !r_active;
                if (w_end) w_state_next = S_IDLE;
            end
            S_IDLE: if (w_tick) begin
                w_start      = 1'b1;
                w_state_next = S_RD_X;
            end
            S_RD_X: if (w_end) begin
                w_start      = 1'b1;
                w_state_next = S_RD_Y;
            end
            S_RD_Y: if (w_end) w_state_next = S_IDLE;
            default: w_state_next = S_INIT;
        endcase
    end
    // free-running poll timer; ticks outside S_IDLE are simply ignored by the FSM
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_timer <= '0;
        else         r_timer <= w_tick ? '0 : r_timer + 1'b1;
    end
    // slot sequencer: 34 half-periods of CLK_DIV cycles each, event m happens at r_half == m-1
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_active   <= 1'b0;
            r_div      <= '0;
            r_half     <= '0;
            r_rx       <= '0;
            o_spi_sck  <= 1'b1;
            o_spi_cs_n <= 1'b1;
            o_spi_mosi <= 1'b0;
        end else if (w_start) begin
            r_active   <= 1'b1;
            r_div      <= '0;
            r_half     <= '0;
            o_spi_cs_n <= 1'b0;
        end else if (w_step) begin
            r_div  <= '0;
            r_half <= r_half + 6'd1;
            if (r_half == 6'd33) begin
                r_active <= 1'b0;
            end else if (r_half == 6'd32) begin
                o_spi_cs_n <= 1'b1;
                o_spi_mosi <= 1'b0;
            end else if (!r_half[0]) begin
                o_spi_sck  <= 1'b0;
                o_spi_mosi <= w_bit;
            end else begin
                o_spi_sck <= 1'b1;
                r_rx      <= {r_rx[6:0], i_spi_miso};
            end
        end else if (r_active) begin
            r_div <= r_div + 1'b1;
        end
    end
    // hold X until Y arrives so both outputs change together with a single valid pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_x_hold  <= '0;
            o_accel_x <= '0;
            o_accel_y <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (w_end && r_state == S_RD_X) r_x_hold <= r_rx;
            if (w_end && r_state == S_RD_Y) begin
                o_accel_x <= r_x_hold;
                o_accel_y <= r_rx;
                o_valid   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: slave model plus scoreboard of expected MOSI words and X/Y samples
module tb_accel_spi_reader;
    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       miso = 1'b1;
    logic [7:0] ax, ay;
    logic       vld, sck, cs_n, mosi;

    accel_spi_reader #(.CLK_DIV(2), .POLL_PERIOD(200)) dut (
        .clk(clk), .arst_n(arst_n), .o_accel_x(ax), .o_accel_y(ay), .o_valid(vld),
        .o_spi_sck(sck), .o_spi_cs_n(cs_n), .o_spi_mosi(mosi), .i_spi_miso(miso)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, n_valid = 0;
    logic [15:0] exp_words[$];
    logic [15:0] exp_pairs[$];
    logic [7:0]  slv_x = 8'h00, slv_y = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int          cyc = 0, t_csf = 0, t_fall = 0, t_rise = 0, t_csr = 0, t_v = 0, nbits = 0;
    bit          have_csr = 0, have_tv = 0;
    logic        p_cs = 1'b1, p_sck = 1'b1, p_v = 1'b0;
    logic [15:0] rx = '0, prev_xy = '0;
    logic [7:0]  sel = '0;

    // slave and monitor: observe away from the active edge, answer with miso on sck falls
    always @(negedge clk) begin
        if (!arst_n) begin
            p_cs = 1'b1; p_sck = 1'b1; p_v = 1'b0; nbits = 0;
            have_csr = 0; have_tv = 0; prev_xy = '0; miso = 1'b1;
        end else begin
            cyc++;
            chk("hold_xy", vld || ({ax, ay} === prev_xy), 1);
            if (vld) begin
                chk("valid_width", p_v, 0);
                if (have_tv) chk("valid_spacing", cyc - t_v, 200);
                have_tv = 1; t_v = cyc; n_valid++;
                chk("valid_expected", exp_pairs.size() != 0, 1);
                if (exp_pairs.size() != 0) chk("sample_xy", {ax, ay}, exp_pairs.pop_front());
            end
            if (cs_n) chk("mosi_idle", mosi, 0);
            if (p_cs && !cs_n) begin
                if (have_csr) chk("cs_gap", (cyc - t_csr) >= 2, 1);
                t_csf = cyc; nbits = 0; rx = '0; miso = 1'b1;
            end
            if (!cs_n && p_sck && !sck) begin
                if (nbits == 0) chk("cs_to_sck", cyc - t_csf, 2);
                else            chk("sck_period", cyc - t_fall, 4);
                t_fall = cyc;
                miso = (nbits < 8) ? 1'b1 : sel[15 - nbits];
            end
            if (!cs_n && !p_sck && sck) begin
                rx = {rx[14:0], mosi}; nbits++; t_rise = cyc;
                if (nbits == 8) sel = (rx[7:0] == 8'hB3) ? slv_x : (rx[7:0] == 8'hB5) ? slv_y : 8'h00;
            end
            if (!p_cs && cs_n) begin
                chk("rise_count", nbits, 16);
                chk("last_rise_to_cs", cyc - t_rise, 2);
                have_csr = 1; t_csr = cyc;
                chk("word_expected", exp_words.size() != 0, 1);
                if (exp_words.size() != 0) chk("mosi_word", rx, exp_words.pop_front());
            end
            p_cs = cs_n; p_sck = sck; p_v = vld; prev_xy = {ax, ay};
        end
    end

    task automatic wait_valid(input int n);
        for (int i = 0; i < 1000 && n_valid < n; i++) @(negedge clk);
        chk("valid_timeout", n_valid >= n, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sck"}, sck, 1);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_mosi"}, mosi, 0);
        chk({tag, "_x"}, ax, 0);
        chk({tag, "_y"}, ay, 0);
        chk({tag, "_valid"}, vld, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        slv_x = 8'h12; slv_y = 8'hF0;
        exp_words.push_back(16'h2D08);
        exp_words.push_back(16'hB300);
        exp_words.push_back(16'hB500);
        exp_pairs.push_back(16'h12F0);
        @(negedge clk);
        arst_n = 1'b1;
        wait_valid(1);
        slv_x = 8'h80; slv_y = 8'h7F;
        exp_words.push_back(16'hB300);
        exp_words.push_back(16'hB500);
        exp_pairs.push_back(16'h807F);
        wait_valid(2);
        for (int i = 0; i < 300 && cs_n; i++) @(negedge clk);
        chk("x_read_start", cs_n, 0);
        repeat (10) @(negedge clk);
        #2 arst_n = 1'b0;
        #1 chk_idle("mid_reset");
        exp_words.delete();
        exp_pairs.delete();
        exp_words.push_back(16'h2D08);
        exp_words.push_back(16'hB300);
        exp_words.push_back(16'hB500);
        exp_pairs.push_back(16'h807F);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        wait_valid(3);
        repeat (5) @(negedge clk);
        chk("words_left", exp_words.size(), 0);
        chk("pairs_left", exp_pairs.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
